// File: rtl/program_loader.sv
// program_loader: receives a framed program image over a byte stream
// (A5, LEN_LO, LEN_HI, payload, optional CHK), writes it into a byte-wide
// program RAM and serves the processor's combinational instruction/constant
// read port. The processor stays held until a complete image is committed.
// Optional feature macro: CHECKSUM_EN. When defined, the frame carries a
// trailing XOR checksum byte that is checked before the image is committed.
module program_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       index,
    output logic [7:0]        instruction,
    output logic [31:0]       constant,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   prog_len
);

    localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR
`ifdef CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_mem [MEM_DEPTH];
    logic [7:0]        r_len_lo;
    logic [ADDR_W:0]   r_pending_len;
    logic [ADDR_W:0]   r_addr;
    logic              r_hold, r_done, r_err;
    logic [ADDR_W:0]   r_prog_len;
`ifdef CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    logic [15:0]       w_len;
    logic              w_start, w_lo, w_clr, w_wr, w_ok, w_fail;
    logic [32:0]       w_plen33, w_a;
    logic [7:0]        w_inst;
    logic [31:0]       w_const;

    assign rx_ready = 1'b1;
    assign w_len    = {rx_data, r_len_lo};

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-byte control strobes.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_lo    = 1'b0;
        w_clr   = 1'b0;
        w_wr    = 1'b0;
        w_ok    = 1'b0;
        w_fail  = 1'b0;
        if (rx_valid) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (rx_data == SYNC) begin
                        w_next  = S_LEN_LO;
                        w_start = 1'b1;
                    end
                end
                S_LEN_LO: begin
                    w_lo   = 1'b1;
                    w_next = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (w_len == 16'd0 || {1'b0, w_len} > DEPTH) begin
                        w_next = S_ERROR;
                        w_fail = 1'b1;
                    end else begin
                        w_next = S_DATA;
                        w_clr  = 1'b1;
                    end
                end
                S_DATA: begin
                    w_wr = !RST;
                    if (r_addr + 1'b1 == r_pending_len) begin
`ifdef CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_next = S_DONE;
                        w_ok   = 1'b1;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (rx_data == r_chk) begin
                        w_next = S_DONE;
                        w_ok   = 1'b1;
                    end else begin
                        w_next = S_ERROR;
                        w_fail = 1'b1;
                    end
                end
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Length/address/checksum bookkeeping and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_len_lo      <= '0;
            r_pending_len <= '0;
            r_addr        <= '0;
            r_hold        <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_prog_len    <= '0;
`ifdef CHECKSUM_EN
            r_chk         <= '0;
`endif
        end else begin
            if (w_start) begin
                r_hold     <= 1'b1;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_prog_len <= '0;
            end
            if (w_lo) r_len_lo <= rx_data;
            if (w_clr) begin
                // Length already bounded by MEM_DEPTH, so it fits ADDR_W+1 bits.
                r_pending_len <= w_len[ADDR_W:0];
                r_addr        <= '0;
`ifdef CHECKSUM_EN
                r_chk         <= '0;
`endif
            end
            if (w_wr) begin
                r_addr <= r_addr + 1'b1;
`ifdef CHECKSUM_EN
                r_chk  <= r_chk ^ rx_data;
`endif
            end
            if (w_ok) begin
                r_prog_len <= r_pending_len;
                r_done     <= 1'b1;
                r_hold     <= 1'b0;
            end
            if (w_fail) r_err <= 1'b1;
        end
    end

    // Program RAM write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_addr[ADDR_W-1:0]] <= rx_data;
    end

    // Combinational read port; bounds are checked in 33 bits so index+k never wraps.
    always_comb begin
        w_plen33 = {{(32-ADDR_W){1'b0}}, r_prog_len};
        w_inst   = 8'hFF;
        w_const  = '0;
        w_a      = '0;
        if ({1'b0, index} < w_plen33) w_inst = r_mem[index[ADDR_W-1:0]];
        for (int k = 1; k <= 4; k++) begin
            w_a = {1'b0, index} + 33'(k);
            if (w_a < w_plen33) w_const[8*(k-1) +: 8] = r_mem[w_a[ADDR_W-1:0]];
        end
    end

    assign instruction = w_inst;
    assign constant    = w_const;
    assign cpu_hold    = r_hold;
    assign load_done   = r_done;
    assign load_error  = r_err;
    assign prog_len    = r_prog_len;

endmodule
